mc_rsp_model: RTL and testbench

//  Responder end of the MC request/response interface: accepts mc_req_ld/mc_req_st from a

---
 rtl/mc_rsp_model.sv | 223 ++++++++++++++++++++++
 tb/tb_mc_rsp_model.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_rsp_model.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mc_rsp_model                                               |
// | Description : Responder end of the MC request/response interface. Loads  |
// |               and stores are queued in order, serviced against an        |
// |               on-chip 64-bit word memory, and load data returns with its |
// |               rdctl tag after a fixed pipeline latency.                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk, r_reset      clock, synchronous active-high reset                  |
// |   mc_req_ld/st      request strobes (exactly one per request)            |
// |   mc_req_vadr       byte address, word index = vadr[ADDR_W+2:3]          |
// |   mc_req_wrd_rdctl  store data, or load tag in [31:0]                    |
// |   mc_rd/wr_rq_stall queue almost full, requester must stop               |
// |   mc_rsp_push       one-cycle load response strobe                       |
// |   mc_rsp_rdctl/data returned tag and data                                |
// |   mc_rsp_stall      requester cannot accept responses                    |
// |   init_we/idx/data  backdoor memory preload                              |
// |   idle              nothing queued or in flight                           |
// |   err               sticky protocol error (cleared by reset only)        |
// +--------------------------------------------------------------------------+
module mc_rsp_model #(
  parameter int ADDR_W    = 10,
  parameter int LATENCY   = 4,
  parameter int REQ_DEPTH = 16,
  parameter int SKID      = 4
) (
  input  logic              clk,
  input  logic              r_reset,
  input  logic              mc_req_ld,
  input  logic              mc_req_st,
  input  logic [47:0]       mc_req_vadr,
  input  logic [63:0]       mc_req_wrd_rdctl,
  output logic              mc_rd_rq_stall,
  output logic              mc_wr_rq_stall,
  output logic              mc_rsp_push,
  output logic [31:0]       mc_rsp_rdctl,
  output logic [63:0]       mc_rsp_data,
  input  logic              mc_rsp_stall,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_idx,
  input  logic [63:0]       init_data,
  output logic              idle,
  output logic              err
);

  localparam int PTR_W     = $clog2(REQ_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int MEM_DEPTH = 1 << ADDR_W;
  localparam int STALL_LVL = REQ_DEPTH - SKID;

  typedef struct packed {
    logic              st;
    logic [ADDR_W-1:0] idx;
    logic [63:0]       wrd;
  } req_t;

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  logic [63:0] mem_q   [MEM_DEPTH];
  req_t        q_mem_q [REQ_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             err_q,    err_d;
  logic             rsp_stall_q;

  // Response pipeline; index 0 is the stage loaded at pop.
  logic        pv_q   [LATENCY];
  logic [31:0] prd_q  [LATENCY];
  logic [63:0] pdat_q [LATENCY];

  // ---------------------------------------------------------------------
  // Request-side decode
  // ---------------------------------------------------------------------
  logic              req_both;
  logic              req_one;
  logic              q_full;
  logic              q_empty;
  logic              enq;
  logic              adv;
  logic              pop;
  req_t              head;
  req_t              new_req;
  logic [63:0]       rd_data;
  logic              any_valid;

  // Address bits outside the word index carry no meaning here.
  logic unused_vadr;
  assign unused_vadr = ^{mc_req_vadr[47:ADDR_W+3], mc_req_vadr[2:0]};

  always_comb begin
    req_both    = mc_req_ld & mc_req_st;
    req_one     = mc_req_ld ^ mc_req_st;
    q_full      = (count_q == CNT_W'(REQ_DEPTH));
    q_empty     = (count_q == '0);
    enq         = req_one & ~q_full;
    // The whole pipe and the queue head freeze on the registered stall, so
    // a response is never presented in a cycle the requester refuses it.
    adv         = ~rsp_stall_q;
    pop         = adv & ~q_empty;
    head        = q_mem_q[rd_ptr_q];
    new_req.st  = mc_req_st;
    new_req.idx = mc_req_vadr[ADDR_W+2:3];
    new_req.wrd = mc_req_wrd_rdctl;
    // Load reads the array before any same-edge write lands, which keeps
    // read-after-write in program order: a store pops one cycle earlier.
    rd_data     = mem_q[head.idx];
  end

  // ---------------------------------------------------------------------
  // Queue pointers, occupancy and error flag
  // ---------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;

    if (enq) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({enq, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (req_both || (req_one && q_full)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      rsp_stall_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      rsp_stall_q <= mc_rsp_stall;
    end
  end

  // Queue entry storage needs no reset: only slots between the pointers
  // are ever read.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_mem_q[wr_ptr_q] <= new_req;
    end
  end

  // ---------------------------------------------------------------------
  // Word memory. Contents survive reset. The backdoor write is issued last
  // so it wins over a same-edge store pop to the same index.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (pop && head.st) begin
      mem_q[head.idx] <= head.wrd;
    end
    if (init_we) begin
      mem_q[init_idx] <= init_data;
    end
  end

  // ---------------------------------------------------------------------
  // Response pipeline. A store pop inserts a bubble so the stage count
  // between a load pop and its push stays constant.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (r_reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pv_q[i]   <= 1'b0;
        prd_q[i]  <= '0;
        pdat_q[i] <= '0;
      end
    end else if (adv) begin
      pv_q[0]   <= pop & ~head.st;
      prd_q[0]  <= head.wrd[31:0];
      pdat_q[0] <= rd_data;
      for (int i = 1; i < LATENCY; i++) begin
        pv_q[i]   <= pv_q[i-1];
        prd_q[i]  <= prd_q[i-1];
        pdat_q[i] <= pdat_q[i-1];
      end
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      any_valid = any_valid | pv_q[i];
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // Stall threshold leaves SKID free slots for requests already committed
  // by the requester's registered stall sample and registered request.
  assign mc_rd_rq_stall = (count_q >= CNT_W'(STALL_LVL));
  assign mc_wr_rq_stall = mc_rd_rq_stall;
  assign mc_rsp_push    = pv_q[LATENCY-1] & adv;
  assign mc_rsp_rdctl   = prd_q[LATENCY-1];
  assign mc_rsp_data    = pdat_q[LATENCY-1];
  assign idle           = q_empty & ~any_valid;
  assign err            = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_rsp_model.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mc_rsp_model                                            |
// | Description : Self-checking bench for mc_rsp_model. A transaction-level  |
// |               model (request queue, memory array, response slot queue)   |
// |               predicts every output each cycle; directed scenarios pin   |
// |               the model with hand-computed values.                       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_mc_rsp_model;

  localparam int LAT       = 4;
  localparam int DEPTH     = 16;
  localparam int STALL_LVL = 12;

  logic        clk = 1'b0;
  logic        r_reset = 1'b0;
  logic        mc_req_ld = 1'b0;
  logic        mc_req_st = 1'b0;
  logic [47:0] mc_req_vadr = '0;
  logic [63:0] mc_req_wrd_rdctl = '0;
  logic        mc_rd_rq_stall;
  logic        mc_wr_rq_stall;
  logic        mc_rsp_push;
  logic [31:0] mc_rsp_rdctl;
  logic [63:0] mc_rsp_data;
  logic        mc_rsp_stall = 1'b0;
  logic        init_we = 1'b0;
  logic [9:0]  init_idx = '0;
  logic [63:0] init_data = '0;
  logic        idle;
  logic        err;

  always #5 clk = ~clk;

  mc_rsp_model #(
    .ADDR_W(10), .LATENCY(LAT), .REQ_DEPTH(DEPTH), .SKID(4)
  ) dut (
    .clk(clk), .r_reset(r_reset),
    .mc_req_ld(mc_req_ld), .mc_req_st(mc_req_st),
    .mc_req_vadr(mc_req_vadr), .mc_req_wrd_rdctl(mc_req_wrd_rdctl),
    .mc_rd_rq_stall(mc_rd_rq_stall), .mc_wr_rq_stall(mc_wr_rq_stall),
    .mc_rsp_push(mc_rsp_push), .mc_rsp_rdctl(mc_rsp_rdctl),
    .mc_rsp_data(mc_rsp_data), .mc_rsp_stall(mc_rsp_stall),
    .init_we(init_we), .init_idx(init_idx), .init_data(init_data),
    .idle(idle), .err(err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: list of pending requests, memory array, list of
  // response slots (front = newest). Updated from the inputs at each edge.
  // ---------------------------------------------------------------------
  typedef struct packed { logic st; logic [9:0] idx; logic [63:0] w; } req_t;
  typedef struct packed { logic v; logic [31:0] tag; logic [63:0] d; } slot_t;

  req_t        mq[$];
  slot_t       mp[$];
  logic [63:0] mm [1024];
  logic        m_rstall = 1'b0;
  logic        m_err    = 1'b0;
  bit          started  = 1'b0;

  initial begin : model_proc
    bit    full;
    slot_t s;
    req_t  h;
    req_t  n;
    forever begin
      @(posedge clk);
      if (r_reset) begin
        mq.delete();
        mp.delete();
        repeat (LAT) mp.push_back('0);
        m_err    = 1'b0;
        m_rstall = 1'b0;
        started  = 1'b1;
      end else if (started) begin
        full = (mq.size() == DEPTH);
        s    = '0;
        if (!m_rstall) begin
          if (mq.size() > 0) begin
            h = mq.pop_front();
            if (h.st) mm[h.idx] = h.w;
            else      s = {1'b1, h.w[31:0], mm[h.idx]};
          end
          void'(mp.pop_back());
          mp.push_front(s);
        end
        if (init_we) mm[init_idx] = init_data;
        if (mc_req_ld && mc_req_st) begin
          m_err = 1'b1;
        end else if (mc_req_ld || mc_req_st) begin
          if (full) m_err = 1'b1;
          else begin
            n = {mc_req_st, mc_req_vadr[12:3], mc_req_wrd_rdctl};
            mq.push_back(n);
          end
        end
        m_rstall = mc_rsp_stall;
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of returned tags.
  logic [31:0] got[$];

  initial begin : compare_proc
    bit any_v;
    bit e_push;
    forever begin
      @(negedge clk);
      if (started) begin
        any_v = 1'b0;
        foreach (mp[i]) any_v |= mp[i].v;
        e_push = mp[LAT-1].v && !m_rstall;
        chk("push", 64'(mc_rsp_push), 64'(e_push));
        chk("rd_rq_stall", 64'(mc_rd_rq_stall), 64'(mq.size() >= STALL_LVL));
        chk("wr_rq_stall", 64'(mc_wr_rq_stall), 64'(mq.size() >= STALL_LVL));
        chk("idle", 64'(idle), 64'(mq.size() == 0 && !any_v));
        chk("err", 64'(err), 64'(m_err));
        if (e_push && mc_rsp_push === 1'b1) begin
          chk("rdctl", 64'(mc_rsp_rdctl), 64'(mp[LAT-1].tag));
          chk("data", mc_rsp_data, mp[LAT-1].d);
        end
      end
      if (mc_rsp_push === 1'b1) got.push_back(mc_rsp_rdctl);
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers. Requester honours stall through a registered sample
  // and a registered request: a request in cycle c sees stall from c-2.
  // ---------------------------------------------------------------------
  logic [1:0] sh = '0;
  bit         ok_send;

  task automatic step();
    @(negedge clk);
    ok_send = !sh[1];
    sh      = {sh[0], mc_rd_rq_stall};
  endtask

  function automatic logic [47:0] vadr_of(input logic [9:0] idx);
    logic [47:0] v;
    v       = {$urandom, $urandom};
    v[12:3] = idx;
    return v;
  endfunction

  function automatic logic [9:0] rand_idx();
    int r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 10'd1023 : 10'(r);
  endfunction

  task automatic drive_ld(input logic [9:0] idx, input logic [31:0] tag);
    mc_req_ld        = 1'b1;
    mc_req_st        = 1'b0;
    mc_req_vadr      = vadr_of(idx);
    mc_req_wrd_rdctl = {$urandom, tag};
  endtask

  task automatic do_reset();
    @(negedge clk);
    r_reset = 1'b1;
    mc_req_ld = 1'b0; mc_req_st = 1'b0; init_we = 1'b0; mc_rsp_stall = 1'b0;
    repeat (2) @(negedge clk);
    r_reset = 1'b0;
    sh = '0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    step();
    mc_req_ld = 1'b0; mc_req_st = 1'b0; init_we = 1'b0; mc_rsp_stall = 1'b0;
    k = 0;
    while (idle !== 1'b1 && k < 300) begin
      step();
      k++;
    end
    chk(nm, 64'(idle), 64'd1);
  endtask

  task automatic wait_push(output logic [31:0] tag, output logic [63:0] d);
    int k;
    k = 0; tag = 'x; d = 'x;
    while (k < 40) begin
      step();
      mc_req_ld = 1'b0; mc_req_st = 1'b0;
      if (mc_rsp_push === 1'b1) begin
        tag = mc_rsp_rdctl; d = mc_rsp_data;
        k = 40;
      end
      k++;
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------
  initial begin : stim
    logic [31:0] t;
    logic [63:0] d;
    int          sent;
    int          c;
    bit          saw_stall;
    int          tag;

    do_reset();
    chk("rst_push",  64'(mc_rsp_push), 64'd0);
    chk("rst_idle",  64'(idle), 64'd1);
    chk("rst_err",   64'(err), 64'd0);
    chk("rst_stall", 64'(mc_rd_rq_stall), 64'd0);
    chk("rst_rdctl", 64'(mc_rsp_rdctl), 64'd0);
    chk("rst_data",  mc_rsp_data, 64'd0);

    // Preload indices 0..63 and the top word.
    for (int i = 0; i < 65; i++) begin
      @(negedge clk);
      init_we   = 1'b1;
      init_idx  = (i == 64) ? 10'd1023 : 10'(i);
      init_data = {$urandom, $urandom};
    end
    @(negedge clk);
    init_we = 1'b1; init_idx = 10'd5; init_data = 64'hDEAD_BEEF_0000_0005;
    @(negedge clk);
    init_we = 1'b0;

    // 1: fixed latency, push five cycles after the request cycle.
    @(negedge clk);
    mc_req_ld = 1'b1; mc_req_vadr = 48'h28; mc_req_wrd_rdctl = 64'h7;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      mc_req_ld = 1'b0;
      if (k == 4) chk("t1_push_early", 64'(mc_rsp_push), 64'd0);
      if (k == 5) begin
        chk("t1_push",  64'(mc_rsp_push), 64'd1);
        chk("t1_rdctl", 64'(mc_rsp_rdctl), 64'h7);
        chk("t1_data",  mc_rsp_data, 64'hDEAD_BEEF_0000_0005);
      end
    end

    // 2: store then load to the same word in the next cycle.
    @(negedge clk);
    mc_req_st = 1'b1; mc_req_vadr = 48'h40; mc_req_wrd_rdctl = 64'h1234;
    @(negedge clk);
    mc_req_st = 1'b0; mc_req_ld = 1'b1; mc_req_vadr = 48'h40; mc_req_wrd_rdctl = 64'h55;
    wait_push(t, d);
    chk("t2_rdctl", 64'(t), 64'h55);
    chk("t2_data",  d, 64'h1234);
    wait_idle("t2_idle");

    // 3: 32 loads against a blocked response port, then drain.
    got.delete(); sent = 0; saw_stall = 1'b0;
    for (c = 0; c < 600 && sent < 32; c++) begin
      step();
      mc_req_ld = 1'b0;
      mc_rsp_stall = (c < 20);
      if (mc_rd_rq_stall === 1'b1) saw_stall = 1'b1;
      if (ok_send) begin
        drive_ld(rand_idx(), 32'(sent));
        sent++;
      end
    end
    wait_idle("t3_idle");
    chk("t3_saw_stall", 64'(saw_stall), 64'd1);
    chk("t3_err", 64'(err), 64'd0);
    chk("t3_count", 64'(got.size()), 64'd32);
    for (int i = 0; i < got.size() && i < 32; i++) chk("t3_tag", 64'(got[i]), 64'(i));

    // 4: response stall for 20 cycles mid-stream of 16 loads.
    got.delete(); sent = 0;
    for (c = 0; c < 400 && (c < 31 || sent < 16); c++) begin
      step();
      mc_req_ld = 1'b0;
      if (ok_send && sent < 16) begin
        drive_ld(rand_idx(), 32'(100 + sent));
        sent++;
      end
      if (c == 10) mc_rsp_stall = 1'b1;
      if (c == 30) mc_rsp_stall = 1'b0;
      if (c > 10 && c <= 30) chk("t4_stalled_push", 64'(mc_rsp_push), 64'd0);
    end
    wait_idle("t4_idle");
    chk("t4_count", 64'(got.size()), 64'd16);
    for (int i = 0; i < got.size() && i < 16; i++) chk("t4_tag", 64'(got[i]), 64'(100 + i));

    // 5: protocol errors.
    @(negedge clk);
    mc_req_ld = 1'b1; mc_req_st = 1'b1; mc_req_vadr = 48'h0;
    @(negedge clk);
    mc_req_ld = 1'b0; mc_req_st = 1'b0;
    chk("t5_both_err",  64'(err), 64'd1);
    chk("t5_both_idle", 64'(idle), 64'd1);
    do_reset();
    chk("t5_rst_err", 64'(err), 64'd0);
    @(negedge clk);
    mc_rsp_stall = 1'b1;
    for (int k = 0; k < 17; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 16) begin
        chk("t5_full_err0", 64'(err), 64'd0);
        chk("t5_full_stall", 64'(mc_rd_rq_stall), 64'd1);
      end
      drive_ld(rand_idx(), 32'(200 + k));
    end
    @(negedge clk);
    mc_req_ld = 1'b0;
    chk("t5_full_err", 64'(err), 64'd1);
    do_reset();

    // 6: reset in the middle of a 10-load burst.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 6) begin
        r_reset = 1'b1;
        mc_req_ld = 1'b0;
      end else if (k > 6) begin
        r_reset = 1'b0;
        mc_req_ld = 1'b0;
      end else begin
        drive_ld(rand_idx(), 32'(300 + k));
      end
      if (k == 8) begin
        chk("t6_push", 64'(mc_rsp_push), 64'd0);
        chk("t6_idle", 64'(idle), 64'd1);
      end
    end
    sh = '0;
    @(negedge clk);
    mc_req_ld = 1'b1; mc_req_vadr = 48'hFFFF_0000_002B; mc_req_wrd_rdctl = 64'h66;
    wait_push(t, d);
    chk("t6_rdctl", 64'(t), 64'h66);
    chk("t6_data",  d, 64'hDEAD_BEEF_0000_0005);
    wait_idle("t6_idle_end");

    // Random traffic: loads, stores, backdoor writes and response stalls.
    tag = 1000;
    for (c = 0; c < 800; c++) begin
      step();
      mc_req_ld = 1'b0; mc_req_st = 1'b0;
      mc_rsp_stall = (c % 100 < 15) ? 1'b1 : ($urandom_range(0, 3) == 0);
      init_we   = ($urandom_range(0, 9) == 0);
      init_idx  = rand_idx();
      init_data = {$urandom, $urandom};
      if (ok_send && $urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 9) < 3) begin
          mc_req_st        = 1'b1;
          mc_req_vadr      = vadr_of(rand_idx());
          mc_req_wrd_rdctl = {$urandom, $urandom};
        end else begin
          drive_ld(rand_idx(), 32'(tag));
          tag++;
        end
      end
    end
    wait_idle("rand_idle");
    chk("rand_err", 64'(err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
